// File: rtl/pe_row_drain.sv
// pe_row_drain: once the whole row is done, selects each PE in turn and streams its accumulator out in index order.
// Latency: 2 cycles select-to-valid per PE, one entry in flight (<= 1 beat per 3 cycles).
// Backpressure: m_* held stable while m_valid_o & !m_ready_i. `define DRAIN_TIMEOUT_EN bounds the per-PE wait.
module pe_row_drain #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_PE         = 4,
    parameter int TIMEOUT_CYCLES = 15,
    parameter int IDX_W          = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         drain_start_i,
    input  logic [NUM_PE-1:0]            pe_done_i,
    input  logic [NUM_PE*DATA_WIDTH-1:0] pe_east_i,
    input  logic [NUM_PE-1:0]            pe_acc_valid_i,
    output logic [NUM_PE-1:0]            pe_select_acc_o,
    output logic [DATA_WIDTH-1:0]        m_data_o,
    output logic [IDX_W-1:0]             m_index_o,
    output logic                         m_last_o,
    output logic                         m_error_o,
    output logic                         m_valid_o,
    input  logic                         m_ready_i,
    output logic                         busy_o,
    output logic                         drain_done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DONE,
        S_WAIT_ACC,
        S_PRESENT,
        S_FINISH
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_PE-1:0]       sel_q;
    logic [DATA_WIDTH-1:0]   east_sel;
    logic                    acc_hit;
    logic                    timeout;
    logic                    capture;
    logic                    unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 1);

    always_comb begin
        east_sel = pe_east_i[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
    end

    // Only the selected PE's valid counts; stale valids from the previous PE fall on another bit.
    assign acc_hit = pe_acc_valid_i[idx_q];
    assign capture = (state_q == S_WAIT_ACC) && (acc_hit || timeout);

`ifdef DRAIN_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counter sits at zero outside WAIT_ACC, so every entry starts a fresh window.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (state_q != S_WAIT_ACC) begin
            cnt_q <= '0;
        end else if (!timeout) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_error_o <= 1'b0;
        end else if (capture) begin
            m_error_o <= !acc_hit;
        end
    end
`else
    assign timeout   = 1'b0;
    assign m_error_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (drain_start_i) begin
                    state_d = S_WAIT_DONE;
                    idx_d   = '0;
                end
            end
            S_WAIT_DONE: begin
                if (&pe_done_i) begin
                    state_d = S_WAIT_ACC;
                end
            end
            S_WAIT_ACC: begin
                if (acc_hit || timeout) begin
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (m_ready_i) begin
                    if (m_last_o) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_WAIT_ACC;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Select follows the next state so it rises on the WAIT_ACC entry edge and drops on capture.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel_q <= '0;
        end else if (state_d == S_WAIT_ACC) begin
            sel_q <= NUM_PE'(1) << idx_d;
        end else begin
            sel_q <= '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_data_o  <= '0;
            m_index_o <= '0;
            m_last_o  <= 1'b0;
            m_valid_o <= 1'b0;
        end else if (capture) begin
            m_data_o  <= acc_hit ? east_sel : '0;
            m_index_o <= idx_q;
            m_last_o  <= (idx_q == LAST_IDX);
            m_valid_o <= 1'b1;
        end else if (m_valid_o && m_ready_i) begin
            m_valid_o <= 1'b0;
        end
    end

    assign pe_select_acc_o = sel_q;
    assign busy_o          = (state_q != S_IDLE);
    assign drain_done_o    = (state_q == S_FINISH);

endmodule

// File: tb/tb_pe_row_drain.sv
// Directed bench for pe_row_drain: drain vectors from a table plus a reset-mid-drain sequence.
`timescale 1ns/1ps
module tb_pe_row_drain;
    localparam int DW = 32;
    localparam int NP = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                   drain_start = 1'b0;
    logic [NP-1:0]          pe_done = '0;
    logic [NP-1:0]          pe_acc_valid = '0;
    logic [NP-1:0]          pe_sel;
    logic [NP-1:0][DW-1:0]  accs = '0;
    logic [NP*DW-1:0]       pe_east;
    logic [DW-1:0]          m_data;
    logic [IW-1:0]          m_index;
    logic                   m_last, m_error, m_valid, busy, drain_done;
    logic                   m_ready = 1'b0;
    logic [NP-1:0]          resp_en = '1;
    logic [NP-1:0]          sel_prev = '0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    assign pe_east = accs;

    pe_row_drain dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .drain_start_i  (drain_start),
        .pe_done_i      (pe_done),
        .pe_east_i      (pe_east),
        .pe_acc_valid_i (pe_acc_valid),
        .pe_select_acc_o(pe_sel),
        .m_data_o       (m_data),
        .m_index_o      (m_index),
        .m_last_o       (m_last),
        .m_error_o      (m_error),
        .m_valid_o      (m_valid),
        .m_ready_i      (m_ready),
        .busy_o         (busy),
        .drain_done_o   (drain_done)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // PE model: accumulator_valid appears one cycle after select is seen, so valid is visible after E+1.
    always @(negedge clk) begin
        pe_acc_valid = sel_prev & resp_en;
        sel_prev     = pe_sel;
    end

    typedef struct {
        logic [NP-1:0][DW-1:0] accs;
        logic [NP-1:0]         resp_en;
        int                    stall;
        int                    done_delay;
        logic [NP-1:0][DW-1:0] exp_data;
        logic [NP-1:0]         exp_err;
        logic [NP-1:0][7:0]    exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_drain(input vec_t v, input string tag);
        int beat = 0;
        int wait_cnt = 0;
        int dones = 0;
        int sel_rise = 0;
        int budget = 0;
        bit onehot = 1'b1;
        bit stable = 1'b1;
        bit wd_ok = 1'b1;
        bit done_early = 1'b0;
        bit extra_beat = 1'b0;
        bit prev_valid = 1'b0;
        bit prev_sel_nz = 1'b0;
        bit post_ok = 1'b1;
        logic [DW-1:0] snap_d = '0;
        logic [IW-1:0] snap_i = '0;

        accs    = v.accs;
        resp_en = v.resp_en;
        pe_done = (v.done_delay > 0) ? 4'b0111 : 4'b1111;
        m_ready = (v.stall == 0);
        @(negedge clk);
        drain_start = 1'b1;
        @(negedge clk);
        drain_start = 1'b0;
        for (int i = 0; i < v.done_delay; i++) begin
            if (pe_sel !== '0 || busy !== 1'b1) wd_ok = 1'b0;
            @(negedge clk);
        end
        if (v.done_delay > 0) chk({tag, " wait_done no select, busy"}, {63'd0, wd_ok}, 64'd1);
        pe_done = 4'b1111;

        while (budget < 400 && !(dones > 0 && beat == NP)) begin
            @(negedge clk);
            budget++;
            if ($countones(pe_sel) > 1) onehot = 1'b0;
            if (pe_sel != '0 && !prev_sel_nz) sel_rise = cyc;
            prev_sel_nz = (pe_sel != '0);
            if (m_valid && !prev_valid && beat < NP)
                chk({tag, " select-to-valid latency"}, 64'(cyc - sel_rise), 64'(v.exp_lat[beat]));
            prev_valid = m_valid;
            if (drain_done) begin
                dones++;
                if (beat != NP) done_early = 1'b1;
            end
            if (m_valid) begin
                if (beat >= NP) extra_beat = 1'b1;
                if (wait_cnt == 0) begin
                    snap_d = m_data;
                    snap_i = m_index;
                end
                if (m_data !== snap_d || m_index !== snap_i) stable = 1'b0;
                if (wait_cnt < v.stall) begin
                    m_ready = 1'b0;
                    wait_cnt++;
                end else begin
                    if (beat < NP) begin
                        chk({tag, " beat index"}, 64'(m_index), 64'(beat));
                        chk({tag, " beat data"}, 64'(m_data), 64'(v.exp_data[beat]));
                        chk({tag, " beat last"}, 64'(m_last), 64'(beat == NP - 1));
                        chk({tag, " beat error"}, 64'(m_error), 64'(v.exp_err[beat]));
                    end
                    m_ready  = 1'b1;
                    beat++;
                    wait_cnt = 0;
                end
            end
        end
        chk({tag, " finished within budget"}, 64'(budget < 400), 64'd1);
        chk({tag, " beat count"}, 64'(beat), 64'(NP));
        chk({tag, " done pulse count"}, 64'(dones), 64'd1);
        chk({tag, " done after last beat"}, 64'(done_early), 64'd0);
        chk({tag, " no extra beat"}, 64'(extra_beat), 64'd0);
        chk({tag, " select one-hot"}, 64'(onehot), 64'd1);
        chk({tag, " data stable while stalled"}, 64'(stable), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (drain_done || busy || m_valid) post_ok = 1'b0;
        end
        chk({tag, " idle after drain"}, 64'(post_ok), 64'd1);
    endtask

    initial begin
        vec_t v;
        bit found;
        bit no_done;

        v.accs     = {32'd40, 32'd30, 32'd20, 32'd10};
        v.resp_en  = 4'b1111;
        v.stall    = 0;
        v.done_delay = 0;
        v.exp_data = {32'd40, 32'd30, 32'd20, 32'd10};
        v.exp_err  = 4'b0000;
        v.exp_lat  = {8'd2, 8'd2, 8'd2, 8'd2};
        vecs.push_back(v);
        v.stall    = 5;
        vecs.push_back(v);
        v.accs     = {32'hFFFF_FFFF, 32'h0000_0001, 32'hDEAD_BEEF, 32'h0000_0000};
        v.exp_data = {32'hFFFF_FFFF, 32'h0000_0001, 32'hDEAD_BEEF, 32'h0000_0000};
        v.stall    = 1;
        v.done_delay = 20;
        vecs.push_back(v);
`ifdef DRAIN_TIMEOUT_EN
        v.accs     = {32'd44, 32'd33, 32'd22, 32'd11};
        v.resp_en  = 4'b1101;
        v.stall    = 0;
        v.done_delay = 0;
        v.exp_data = {32'd44, 32'd33, 32'd0, 32'd11};
        v.exp_err  = 4'b0010;
        v.exp_lat  = {8'd2, 8'd2, 8'd15, 8'd2};
        vecs.push_back(v);
`endif

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset m_valid", 64'(m_valid), 64'd0);
        chk("reset select", 64'(pe_sel), 64'd0);
        chk("reset busy/done", 64'({busy, drain_done, m_last, m_error}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            run_drain(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while PE 2's entry is presented
        accs    = {32'd4, 32'd3, 32'd2, 32'd1};
        resp_en = 4'b1111;
        pe_done = 4'b1111;
        m_ready = 1'b1;
        @(negedge clk);
        drain_start = 1'b1;
        @(negedge clk);
        drain_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (m_valid && m_index == 2'd2) found = 1'b1;
        end
        chk("rst-mid reached PE2", 64'(found), 64'd1);
        m_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst-mid m_valid", 64'(m_valid), 64'd0);
        chk("rst-mid m_data", 64'(m_data), 64'd0);
        chk("rst-mid m_index/last", 64'({m_index, m_last}), 64'd0);
        chk("rst-mid select", 64'(pe_sel), 64'd0);
        chk("rst-mid busy", 64'(busy), 64'd0);
        no_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (drain_done) no_done = 1'b0;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (drain_done || busy) no_done = 1'b0;
        end
        chk("rst-mid no done pulse", 64'(no_done), 64'd1);
        run_drain(vecs[0], "post-reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end
endmodule
